// File: rtl/switch_bounce_generator.sv
// rtl/switch_bounce_generator.sv - mechanical switch emulator producing an LFSR-timed
// contact-bounce burst on every change of the requested level.
module switch_bounce_generator #(
  parameter logic        INITIAL_VALUE = 1'b0,
  parameter int unsigned BOUNCE_CYCLES = 50_000,
  parameter int unsigned MAX_GAP_LOG2  = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_in,
  output logic       sw_out,
  output logic       busy,
  output logic       settled,
  output logic [7:0] bounce_count
);

  localparam logic [15:0] SEED        = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam logic [19:0] WINDOW_LOAD = 20'(BOUNCE_CYCLES - 1);
  localparam logic [MAX_GAP_LOG2-1:0] GAP_ONE = (MAX_GAP_LOG2)'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    sw_out_q, sw_out_d;
  logic                    settled_level_q, settled_level_d;
  logic                    target_q, target_d;
  logic                    busy_q, busy_d;
  logic                    settled_q, settled_d;
  logic [7:0]              bounce_count_q, bounce_count_d;
  logic [19:0]             window_q, window_d;
  logic [MAX_GAP_LOG2-1:0] gap_q, gap_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [MAX_GAP_LOG2-1:0] gap_value;

  // Forcing bit 0 keeps every inter-toggle gap at least one cycle long.
  assign gap_value = lfsr_q[MAX_GAP_LOG2-1:0] | GAP_ONE;

  always_comb begin
    state_d         = state_q;
    sw_out_d        = sw_out_q;
    settled_level_d = settled_level_q;
    target_d        = target_q;
    busy_d          = busy_q;
    settled_d       = 1'b0;
    bounce_count_d  = bounce_count_q;
    window_d        = window_q;
    gap_d           = gap_q;
    lfsr_d          = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    case (state_q)
      IDLE: begin
        if (level_in != settled_level_q) begin
          target_d       = level_in;
          sw_out_d       = level_in;
          busy_d         = 1'b1;
          bounce_count_d = 8'd0;
          window_d       = WINDOW_LOAD;
          gap_d          = gap_value;
          state_d        = BOUNCE;
        end
      end
      BOUNCE: begin
        // The final-level assignment takes priority over a toggle due in the same cycle.
        if (window_q == 20'd0) begin
          sw_out_d        = target_q;
          settled_level_d = target_q;
          busy_d          = 1'b0;
          settled_d       = 1'b1;
          state_d         = IDLE;
        end else begin
          window_d = window_q - 20'd1;
          if (gap_q == GAP_ONE) begin
            sw_out_d = ~sw_out_q;
            gap_d    = gap_value;
            if (bounce_count_q != 8'hFF) begin
              bounce_count_d = bounce_count_q + 8'd1;
            end
          end else begin
            gap_d = gap_q - GAP_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      sw_out_q        <= INITIAL_VALUE;
      settled_level_q <= INITIAL_VALUE;
      target_q        <= INITIAL_VALUE;
      busy_q          <= 1'b0;
      settled_q       <= 1'b0;
      bounce_count_q  <= 8'd0;
      window_q        <= 20'd0;
      gap_q           <= '0;
      lfsr_q          <= SEED;
    end else begin
      state_q         <= state_d;
      sw_out_q        <= sw_out_d;
      settled_level_q <= settled_level_d;
      target_q        <= target_d;
      busy_q          <= busy_d;
      settled_q       <= settled_d;
      bounce_count_q  <= bounce_count_d;
      window_q        <= window_d;
      gap_q           <= gap_d;
      lfsr_q          <= lfsr_d;
    end
  end

  assign sw_out       = sw_out_q;
  assign busy         = busy_q;
  assign settled      = settled_q;
  assign bounce_count = bounce_count_q;

endmodule
